// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS HI/LO unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO) with iterative shift-add and restoring divide.
// Define MULT_DIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle combinational one.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state, next_state;
    logic [4:0]  count;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic        is_div, neg_q, neg_r, div_zero;

    logic        is_mul_op, is_div_op, signed_op, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_shift;
    logic        div_ge;
    logic [31:0] div_rem, fin_q, fin_r;
    logic [63:0] mul_step, div_step, fin_prod;

    always_comb begin
        is_mul_op = (op_i == OP_MULT) || (op_i == OP_MULTU);
        is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVU);
        signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
        a_neg     = signed_op & rs_i[31];
        b_neg     = signed_op & rt_i[31];
        mag_a     = a_neg ? -rs_i : rs_i;
        mag_b     = b_neg ? -rt_i : rt_i;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        mul_sum   = acc[0] ? ({1'b0, acc[63:32]} + {1'b0, opnd}) : {1'b0, acc[63:32]};
        mul_step  = {mul_sum, acc[31:1]};
        div_shift = acc[63:31];
        div_ge    = div_shift >= {1'b0, opnd};
        div_rem   = div_ge ? (div_shift[31:0] - opnd) : div_shift[31:0];
        div_step  = {div_rem, acc[30:0], div_ge};
        fin_prod  = neg_q ? -acc : acc;
        fin_q     = div_zero ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
        fin_r     = neg_r ? -acc[63:32] : acc[63:32];
    end

`ifdef MULT_DIV_FAST_MULT_EN
    logic [63:0] fast_prod;

    always_comb begin
        fast_prod = signed_op ? ({{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i})
                              : ({32'd0, rs_i} * {32'd0, rt_i});
    end
`else
`endif

    always_ff @(posedge clk) begin
        if (!reset_i) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_i) begin
`ifdef MULT_DIV_FAST_MULT_EN
`else
                    if (is_mul_op) next_state = MUL;
`endif
                    if (is_div_op) next_state = DIV;
                end
            end
            MUL, DIV: if (count == 5'd31) next_state = FIN;
            FIN:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // HI/LO are only written at accept (MTHI/MTLO, fast multiply) or at FIN, never mid-iteration
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            count    <= 5'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (op_i == OP_MTHI) begin
                            hi_o   <= rs_i;
                            done_o <= 1'b1;
                        end
                        if (op_i == OP_MTLO) begin
                            lo_o   <= rs_i;
                            done_o <= 1'b1;
                        end
                        if (is_mul_op) begin
`ifdef MULT_DIV_FAST_MULT_EN
                            {hi_o, lo_o} <= fast_prod;
                            done_o       <= 1'b1;
`else
                            acc    <= {32'd0, mag_b};
                            opnd   <= mag_a;
                            neg_q  <= a_neg ^ b_neg;
                            is_div <= 1'b0;
                            count  <= 5'd0;
                            busy_o <= 1'b1;
`endif
                        end
                        if (is_div_op) begin
                            acc      <= {32'd0, mag_a};
                            opnd     <= mag_b;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= (rt_i == 32'd0);
                            is_div   <= 1'b1;
                            count    <= 5'd0;
                            busy_o   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_step;
                    count <= count + 5'd1;
                end
                DIV: begin
                    acc   <= div_step;
                    count <= count + 5'd1;
                end
                FIN: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    if (is_div) begin
                        hi_o <= fin_r;
                        lo_o <= fin_q;
                    end else begin
                        {hi_o, lo_o} <= fin_prod;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
// Honours MULT_DIV_FAST_MULT_EN for expected multiply latency.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs_i = 32'd0;
    logic [31:0] rt_i = 32'd0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int passed = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mult_div_unit dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .rs_i(rs_i), .rt_i(rt_i), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: {HI, LO} after op, given the previous HI/LO
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = {h, l};
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            3'd4: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            3'd5: r = {a, l};
            3'd6: r = {h, a};
            default: r = {h, l};
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        if (op == 3'd5 || op == 3'd6) return 0;
        if ((op == 3'd1 || op == 3'd2) && FAST) return 0;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op; lat = edges after the accept edge until done_o is seen (-1 on timeout)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output bit hold_ok, output bit done_ok);
        logic [31:0] h0, l0;
        h0 = hi_o;
        l0 = lo_o;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = 3'($urandom_range(0, 7)); rs_i = $urandom; rt_i = $urandom;
        lat = -1; busy_cnt = 0; hold_ok = 1'b1; done_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done_o) begin
                lat = k;
                if (busy_o) done_ok = 1'b0;
                break;
            end
            if (busy_o) begin
                busy_cnt++;
                if (hi_o !== h0 || lo_o !== l0) hold_ok = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi_o !== 32'd0) $display("[TB] FAIL reset_hi got=%h exp=0", hi_o); else passed++;
        checks++; if (lo_o !== 32'd0) $display("[TB] FAIL reset_lo got=%h exp=0", lo_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); else passed++;
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL reset_done got=%b exp=0", done_o); else passed++;
        @(negedge clk);
        reset_i = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mthi_mtlo;
        int lat, bc;
        bit hold, dok;
        logic [2:0]  ops [2] = '{3'd5, 3'd6};
        logic [31:0] vals[2] = '{32'h1234_5678, 32'h9ABC_DEF0};
        for (int i = 0; i < 2; i++) begin
            logic [63:0] exp;
            exp = model(ops[i], vals[i], 32'd0, m_hi, m_lo);
            run_op(ops[i], vals[i], 32'd0, lat, bc, hold, dok);
            checks++; if ({hi_o, lo_o} !== exp) $display("[TB] FAIL mt_value op=%0d got=%h exp=%h", ops[i], {hi_o, lo_o}, exp); else passed++;
            checks++; if (lat !== 0) $display("[TB] FAIL mt_latency op=%0d got=%0d exp=0", ops[i], lat); else passed++;
            checks++; if (bc !== 0 || !dok) $display("[TB] FAIL mt_busy op=%0d busy_cycles=%0d exp=0", ops[i], bc); else passed++;
            @(posedge clk); #1;
            checks++; if (done_o !== 1'b0) $display("[TB] FAIL mt_done_pulse op=%0d got=%b exp=0", ops[i], done_o); else passed++;
            m_hi = exp[63:32]; m_lo = exp[31:0];
        end
    endtask

    task automatic test_mult;
        int lat, bc;
        bit hold, dok;
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [63:0] exp;
            if (i < 2) begin
                op = (i == 0) ? 3'd1 : 3'd2; a = 32'hFFFF_FFFE; b = 32'd3;
            end else begin
                op = 3'($urandom_range(1, 2)); a = pick(); b = pick();
            end
            exp = model(op, a, b, m_hi, m_lo);
            run_op(op, a, b, lat, bc, hold, dok);
            checks++; if (hi_o !== exp[63:32]) $display("[TB] FAIL mult_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, hi_o, exp[63:32]); else passed++;
            checks++; if (lo_o !== exp[31:0]) $display("[TB] FAIL mult_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, lo_o, exp[31:0]); else passed++;
            checks++; if (lat !== exp_lat(op)) $display("[TB] FAIL mult_latency op=%0d got=%0d exp=%0d", op, lat, exp_lat(op)); else passed++;
            checks++; if (bc !== exp_lat(op)) $display("[TB] FAIL mult_busy op=%0d got=%0d exp=%0d", op, bc, exp_lat(op)); else passed++;
            checks++; if (!hold || !dok) $display("[TB] FAIL mult_hold op=%0d hold=%b done_clean=%b exp=1", op, hold, dok); else passed++;
            m_hi = exp[63:32]; m_lo = exp[31:0];
        end
    endtask

    task automatic test_div;
        int lat, bc;
        bit hold, dok;
        logic [2:0]  dops[4] = '{3'd3, 3'd4, 3'd3, 3'd3};
        logic [31:0] das [4] = '{32'hFFFF_FFF9, 32'd100, 32'h55, 32'h8000_0000};
        logic [31:0] dbs [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 14; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [63:0] exp;
            if (i < 4) begin
                op = dops[i]; a = das[i]; b = dbs[i];
            end else begin
                op = 3'($urandom_range(3, 4)); a = pick(); b = pick();
            end
            exp = model(op, a, b, m_hi, m_lo);
            run_op(op, a, b, lat, bc, hold, dok);
            checks++; if (hi_o !== exp[63:32]) $display("[TB] FAIL div_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, hi_o, exp[63:32]); else passed++;
            checks++; if (lo_o !== exp[31:0]) $display("[TB] FAIL div_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, lo_o, exp[31:0]); else passed++;
            checks++; if (lat !== 33) $display("[TB] FAIL div_latency op=%0d got=%0d exp=33", op, lat); else passed++;
            checks++; if (bc !== 33) $display("[TB] FAIL div_busy op=%0d got=%0d exp=33", op, bc); else passed++;
            checks++; if (!hold || !dok) $display("[TB] FAIL div_hold op=%0d hold=%b done_clean=%b exp=1", op, hold, dok); else passed++;
            m_hi = exp[63:32]; m_lo = exp[31:0];
        end
    endtask

    task automatic test_none;
        bit saw;
        logic [2:0] nops[2] = '{3'd0, 3'd7};
        for (int i = 0; i < 2; i++) begin
            saw = 1'b0;
            @(negedge clk);
            start_i = 1'b1; op_i = nops[i]; rs_i = $urandom; rt_i = $urandom;
            @(posedge clk); #1;
            start_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (done_o || busy_o) saw = 1'b1;
                @(posedge clk); #1;
            end
            checks++; if (saw !== 1'b0) $display("[TB] FAIL none_activity op=%0d got=1 exp=0", nops[i]); else passed++;
            checks++; if ({hi_o, lo_o} !== {m_hi, m_lo}) $display("[TB] FAIL none_hilo op=%0d got=%h exp=%h", nops[i], {hi_o, lo_o}, {m_hi, m_lo}); else passed++;
        end
    endtask

    task automatic test_abort;
        bit saw_done, changed, busy_mid;
        saw_done = 1'b0; changed = 1'b0; busy_mid = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd3; rs_i = 32'd1000; rt_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_i = (c == 10);
            op_i = 3'd6; rs_i = 32'hDEAD_BEEF;
            if (c == 20) reset_i = 1'b0;
            @(posedge clk); #1;
            start_i = 1'b0;
            if (done_o) saw_done = 1'b1;
            if (c < 20 && (hi_o !== m_hi || lo_o !== m_lo)) changed = 1'b1;
            if (c == 15) busy_mid = busy_o;
        end
        checks++; if (busy_mid !== 1'b1) $display("[TB] FAIL abort_busy_mid got=%b exp=1", busy_mid); else passed++;
        checks++; if (changed !== 1'b0) $display("[TB] FAIL abort_mtlo_ignored got=1 exp=0"); else passed++;
        checks++; if ({hi_o, lo_o} !== 64'd0) $display("[TB] FAIL abort_hilo got=%h exp=0", {hi_o, lo_o}); else passed++;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL abort_busy got=%b exp=0", busy_o); else passed++;
        @(negedge clk);
        reset_i = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) $display("[TB] FAIL abort_done got=1 exp=0"); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        bit hold, dok;
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, hold, dok);
        checks++; if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001) $display("[TB] FAIL b2b_mult got=%h exp=fffffffe00000001", {hi_o, lo_o}); else passed++;
        checks++; if (lat !== exp_lat(3'd2)) $display("[TB] FAIL b2b_mult_latency got=%0d exp=%0d", lat, exp_lat(3'd2)); else passed++;
        run_op(3'd4, 32'd9, 32'd4, lat, bc, hold, dok);
        checks++; if ({hi_o, lo_o} !== {32'd1, 32'd2}) $display("[TB] FAIL b2b_div got=%h exp=0000000100000002", {hi_o, lo_o}); else passed++;
        checks++; if (lat !== 33 || !hold) $display("[TB] FAIL b2b_div_timing lat=%0d hold=%b exp lat=33 hold=1", lat, hold); else passed++;
        m_hi = 32'd1; m_lo = 32'd2;
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_none();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
